// File: rtl/operand_fetch_stage_pkg.sv
// Shared instruction-set types: opcodes, flags, register file
// geometry and the execute-stage register bundle.
package InstructionSetPkg;

  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 8;
  localparam int RegCount       = 8;
  localparam int RegSelWidth    = $clog2(RegCount);

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpAdc = 4'd1,
    OpSub = 4'd2,
    OpAnd = 4'd3,
    OpOr  = 4'd4,
    OpXor = 4'd5,
    OpLil = 4'd6,
    OpLih = 4'd7,
    OpRor = 4'd8,
    OpRol = 4'd9,
    OpMov = 4'd10
  } eOperation;

  typedef struct packed {
    logic Carry;
    logic Zero;
    logic Negative;
    logic Overflow;
  } sFlags;

  typedef struct packed {
    logic                      ExValid;
    eOperation                 Operation;
    logic [ImmediateWidth-1:0] Imm;
    logic [RegSelWidth-1:0]    DestSel;
    logic [DataWidth-1:0]      SrcVal;
    logic [DataWidth-1:0]      DestVal;
  } sExecute;

  // Operand bypass: take the retiring result when it targets sel.
  function automatic logic [DataWidth-1:0] fwd_operand(
    input logic                   wb_en,
    input logic [RegSelWidth-1:0] wb_sel,
    input logic [DataWidth-1:0]   wb_data,
    input logic [RegSelWidth-1:0] sel,
    input logic [DataWidth-1:0]   rf_data
  );
    return (wb_en && (wb_sel == sel)) ? wb_data : rf_data;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_register_file.sv
// General register file: two combinational read ports and one
// synchronous write port, cleared by synchronous reset.
module operand_fetch_stage_register_file
  import InstructionSetPkg::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [RegSelWidth-1:0] RdSelA,
  output logic [DataWidth-1:0]   RdDataA,
  input  logic [RegSelWidth-1:0] RdSelB,
  output logic [DataWidth-1:0]   RdDataB,
  input  logic                   WrEn,
  input  logic [RegSelWidth-1:0] WrSel,
  input  logic [DataWidth-1:0]   WrData
);

  logic [DataWidth-1:0] regs_q [RegCount];
  logic [DataWidth-1:0] regs_d [RegCount];

  assign RdDataA = regs_q[RdSelA];
  assign RdDataB = regs_q[RdSelB];

  // Next register contents: one entry replaced on write.
  always_comb begin
    regs_d = regs_q;
    if (WrEn) regs_d[WrSel] = WrData;
  end

  // Register storage with synchronous clear.
  always_ff @(posedge Clock) begin
    if (Reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads and forwards operands into the execute
// register, presents them to the ALU and retires its result.
module operand_fetch_stage
  import InstructionSetPkg::*;
(
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  eOperation                 InOperation,
  input  logic [RegSelWidth-1:0]    InSrcSel,
  input  logic [RegSelWidth-1:0]    InDestSel,
  input  logic [ImmediateWidth-1:0] InImm,
  input  logic                      Stall,
  output eOperation                 AluOperation,
  output logic [ImmediateWidth-1:0] AluImm,
  output logic [DataWidth-1:0]      AluSrc,
  output logic [DataWidth-1:0]      AluDest,
  output sFlags                     AluInFlags,
  input  logic [DataWidth-1:0]      AluOutDest,
  input  sFlags                     AluOutFlags,
  output logic                      WbValid,
  output logic [RegSelWidth-1:0]    WbSel,
  output logic [DataWidth-1:0]      WbData,
  output sFlags                     Flags
);

  sExecute ex_q, ex_d;
  sFlags   flags_q, flags_d;

  logic                 accept;
  logic                 wb_valid;
  logic [DataWidth-1:0] rf_src, rf_dest;
  logic [DataWidth-1:0] src_val, dest_val;

  assign InReady  = ~(ex_q.ExValid & Stall);
  assign accept   = InValid & InReady;
  assign wb_valid = ex_q.ExValid & ~Stall;

  operand_fetch_stage_register_file u_rf (
    .Clock   (Clock),
    .Reset   (Reset),
    .RdSelA  (InSrcSel),
    .RdDataA (rf_src),
    .RdSelB  (InDestSel),
    .RdDataB (rf_dest),
    .WrEn    (wb_valid),
    .WrSel   (ex_q.DestSel),
    .WrData  (AluOutDest)
  );

  // Bypass the retiring result into both operands independently.
  always_comb begin
    src_val  = fwd_operand(wb_valid, ex_q.DestSel, AluOutDest,
                           InSrcSel, rf_src);
    dest_val = fwd_operand(wb_valid, ex_q.DestSel, AluOutDest,
                           InDestSel, rf_dest);
  end

  // Execute register: load on accept, drain on retire, hold on stall.
  always_comb begin
    ex_d    = ex_q;
    flags_d = flags_q;
    if (accept) begin
      ex_d.ExValid   = 1'b1;
      ex_d.Operation = InOperation;
      ex_d.Imm       = InImm;
      ex_d.DestSel   = InDestSel;
      ex_d.SrcVal    = src_val;
      ex_d.DestVal   = dest_val;
    end else if (wb_valid) begin
      ex_d.ExValid = 1'b0;
    end
    if (wb_valid) flags_d = AluOutFlags;
  end

  // Pipeline and flag state with synchronous clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ex_q    <= '0;
      flags_q <= '0;
    end else begin
      ex_q    <= ex_d;
      flags_q <= flags_d;
    end
  end

  assign AluOperation = ex_q.Operation;
  assign AluImm       = ex_q.Imm;
  assign AluSrc       = ex_q.SrcVal;
  assign AluDest      = ex_q.DestVal;
  assign AluInFlags   = flags_q;
  assign WbValid      = wb_valid;
  assign WbSel        = ex_q.DestSel;
  assign WbData       = AluOutDest;
  assign Flags        = flags_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural ALU
// and a sequential reference model for a random stream.
module tb_operand_fetch_stage;
  import InstructionSetPkg::*;

  logic                      Clock;
  logic                      Reset;
  logic                      InValid;
  logic                      InReady;
  eOperation                 InOperation;
  logic [RegSelWidth-1:0]    InSrcSel;
  logic [RegSelWidth-1:0]    InDestSel;
  logic [ImmediateWidth-1:0] InImm;
  logic                      Stall;
  eOperation                 AluOperation;
  logic [ImmediateWidth-1:0] AluImm;
  logic [DataWidth-1:0]      AluSrc;
  logic [DataWidth-1:0]      AluDest;
  sFlags                     AluInFlags;
  logic [DataWidth-1:0]      AluOutDest;
  sFlags                     AluOutFlags;
  logic                      WbValid;
  logic [RegSelWidth-1:0]    WbSel;
  logic [DataWidth-1:0]      WbData;
  sFlags                     Flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] r;
    sFlags       f;
  } alu_res_t;

  operand_fetch_stage dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .InValid      (InValid),
    .InReady      (InReady),
    .InOperation  (InOperation),
    .InSrcSel     (InSrcSel),
    .InDestSel    (InDestSel),
    .InImm        (InImm),
    .Stall        (Stall),
    .AluOperation (AluOperation),
    .AluImm       (AluImm),
    .AluSrc       (AluSrc),
    .AluDest      (AluDest),
    .AluInFlags   (AluInFlags),
    .AluOutDest   (AluOutDest),
    .AluOutFlags  (AluOutFlags),
    .WbValid      (WbValid),
    .WbSel        (WbSel),
    .WbData       (WbData),
    .Flags        (Flags)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic alu_res_t alu(
    input eOperation   op,
    input logic [15:0] s,
    input logic [15:0] d,
    input logic [7:0]  imm,
    input sFlags       fi
  );
    alu_res_t    o;
    logic [16:0] w;
    logic        upd;
    o.r = '0;
    o.f = fi;
    w   = '0;
    upd = 1'b1;
    case (op)
      OpAdd, OpAdc: begin
        w = {1'b0, d} + {1'b0, s}
          + ((op == OpAdc) ? 17'(fi.Carry) : 17'd0);
        o.r = w[15:0];
        o.f.Carry = w[16];
        o.f.Overflow = (d[15] == s[15]) && (o.r[15] != d[15]);
      end
      OpSub: begin
        w = {1'b0, d} - {1'b0, s};
        o.r = w[15:0];
        o.f.Carry = w[16];
        o.f.Overflow = (d[15] != s[15]) && (o.r[15] != d[15]);
      end
      OpAnd: begin o.r = d & s; o.f.Carry = 0; o.f.Overflow = 0; end
      OpOr:  begin o.r = d | s; o.f.Carry = 0; o.f.Overflow = 0; end
      OpXor: begin o.r = d ^ s; o.f.Carry = 0; o.f.Overflow = 0; end
      OpLil: begin o.r = {d[15:8], imm}; upd = 0; end
      OpLih: begin o.r = {imm, d[7:0]}; upd = 0; end
      OpRor: begin
        o.r = {s[0], s[15:1]};
        o.f.Carry = s[0];
        o.f.Overflow = 0;
      end
      OpRol: begin
        o.r = {s[14:0], s[15]};
        o.f.Carry = s[15];
        o.f.Overflow = 0;
      end
      OpMov: begin o.r = s; upd = 0; end
      default: begin o.f = '0; upd = 0; end
    endcase
    if (upd) begin
      o.f.Zero = (o.r == 16'h0);
      o.f.Negative = o.r[15];
    end
    return o;
  endfunction

  alu_res_t alu_now;
  always_comb alu_now = alu(AluOperation, AluSrc, AluDest,
                            AluImm, AluInFlags);
  assign AluOutDest  = alu_now.r;
  assign AluOutFlags = alu_now.f;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input eOperation op, input logic [2:0] s,
                       input logic [2:0] d, input logic [7:0] imm);
    InValid = 1'b1;
    InOperation = op;
    InSrcSel = s;
    InDestSel = d;
    InImm = imm;
    @(posedge Clock);
    @(negedge Clock);
    InValid = 1'b0;
  endtask

  task automatic idle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  logic [15:0] ref_regs [8];
  sFlags       ref_flags;
  alu_res_t    ref_res;
  int          n_acc;
  int          n_cyc;
  logic [3:0]  rop;

  initial begin
    Reset = 1'b1;
    InValid = 1'b0;
    InOperation = OpAdd;
    InSrcSel = '0;
    InDestSel = '0;
    InImm = '0;
    Stall = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rst_inready", 32'(InReady), 32'h1);
    chk("rst_wbvalid", 32'(WbValid), 32'h0);
    chk("rst_aluop", 32'(AluOperation), 32'h0);
    chk("rst_alusrc", 32'(AluSrc), 32'h0);
    chk("rst_aludest", 32'(AluDest), 32'h0);
    chk("rst_aluimm", 32'(AluImm), 32'h0);
    chk("rst_flags", 32'(Flags), 32'h0);

    // Reset mid-stream
    issue(OpLil, 3'd0, 3'd3, 8'h05);
    idle();
    chk("r3_loaded", 32'(dut.u_rf.regs_q[3]), 32'h5);
    issue(OpLil, 3'd0, 3'd2, 8'h03);
    chk("pre_rst_wb", 32'(WbValid), 32'h1);
    Reset = 1'b1;
    InValid = 1'b1;
    InOperation = OpLil;
    InDestSel = 3'd1;
    InImm = 8'h09;
    idle();
    Reset = 1'b0;
    InValid = 1'b0;
    #1;
    chk("mid_rst_wbvalid", 32'(WbValid), 32'h0);
    chk("mid_rst_inready", 32'(InReady), 32'h1);
    chk("mid_rst_flags", 32'(Flags), 32'h0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("mid_rst_r%0d", i),
          32'(dut.u_rf.regs_q[i]), 32'h0);

    // LIL R1,#7 then dependent ADC R2,R1
    issue(OpLil, 3'd0, 3'd2, 8'h03);
    issue(OpLil, 3'd0, 3'd1, 8'h07);
    issue(OpAdc, 3'd1, 3'd2, 8'h00);
    chk("adc_alusrc", 32'(AluSrc), 32'h7);
    chk("adc_aludest", 32'(AluDest), 32'h3);
    chk("adc_aluop", 32'(AluOperation), 32'(OpAdc));
    idle();
    chk("adc_r2", 32'(dut.u_rf.regs_q[2]), 32'd10);
    chk("adc_r1", 32'(dut.u_rf.regs_q[1]), 32'd7);
    chk("adc_flags", 32'(Flags), 32'h0);

    // Same-register forwarding
    issue(OpLih, 3'd0, 3'd4, 8'h40);
    issue(OpAdc, 3'd4, 3'd4, 8'h00);
    chk("adc1_src", 32'(AluSrc), 32'h4000);
    chk("adc1_dest", 32'(AluDest), 32'h4000);
    chk("adc1_result", 32'(WbData), 32'h8000);
    issue(OpAdc, 3'd4, 3'd4, 8'h00);
    chk("adc2_src", 32'(AluSrc), 32'h8000);
    chk("adc2_dest", 32'(AluDest), 32'h8000);
    chk("adc2_inflags", 32'(AluInFlags), 32'b0011);
    chk("adc1_r4", 32'(dut.u_rf.regs_q[4]), 32'h8000);
    idle();
    chk("adc2_r4", 32'(dut.u_rf.regs_q[4]), 32'h0);
    chk("adc2_flags", 32'(Flags), 32'b1101);

    // Stall for three cycles with a held instruction
    issue(OpLil, 3'd0, 3'd7, 8'hAA);
    Stall = 1'b1;
    InValid = 1'b1;
    InOperation = OpLil;
    InSrcSel = 3'd0;
    InDestSel = 3'd6;
    InImm = 8'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_inready", 32'(InReady), 32'h0);
      chk("stall_wbvalid", 32'(WbValid), 32'h0);
      chk("stall_aluimm", 32'(AluImm), 32'hAA);
      chk("stall_aluop", 32'(AluOperation), 32'(OpLil));
      idle();
      chk("stall_r7", 32'(dut.u_rf.regs_q[7]), 32'h0);
    end
    Stall = 1'b0;
    #1;
    chk("release_wbvalid", 32'(WbValid), 32'h1);
    chk("release_inready", 32'(InReady), 32'h1);
    idle();
    InValid = 1'b0;
    chk("release_r7", 32'(dut.u_rf.regs_q[7]), 32'hAA);
    chk("release_imm", 32'(AluImm), 32'h55);
    chk("release_wbsel", 32'(WbSel), 32'h6);
    idle();
    chk("release_r6", 32'(dut.u_rf.regs_q[6]), 32'h55);
    chk("release_wbvalid_off", 32'(WbValid), 32'h0);

    // Rotates through forwarded operands
    issue(OpLil, 3'd0, 3'd6, 8'h01);
    issue(OpRor, 3'd6, 3'd5, 8'h00);
    chk("ror_src", 32'(AluSrc), 32'h1);
    chk("ror_inflags", 32'(AluInFlags), 32'b1101);
    issue(OpRol, 3'd5, 3'd5, 8'h00);
    chk("ror_r5", 32'(dut.u_rf.regs_q[5]), 32'h8000);
    chk("ror_flags", 32'(Flags), 32'b1010);
    chk("rol_src", 32'(AluSrc), 32'h8000);
    idle();
    chk("rol_r5", 32'(dut.u_rf.regs_q[5]), 32'h1);
    chk("rol_flags", 32'(Flags), 32'b1000);

    // Random stream against a sequential model
    Reset = 1'b1;
    idle();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    ref_flags = '0;
    n_acc = 0;
    n_cyc = 0;
    while (n_acc < 1000 && n_cyc < 20000) begin
      Stall = ($urandom_range(0, 3) == 0);
      InValid = ($urandom_range(0, 3) != 0);
      rop = 4'($urandom_range(0, 15));
      InOperation = eOperation'(rop);
      InSrcSel = 3'($urandom_range(0, 7));
      InDestSel = 3'($urandom_range(0, 7));
      InImm = 8'($urandom_range(0, 255));
      #1;
      if (InValid && InReady) begin
        ref_res = alu(InOperation, ref_regs[InSrcSel],
                      ref_regs[InDestSel], InImm, ref_flags);
        ref_regs[InDestSel] = ref_res.r;
        ref_flags = ref_res.f;
        n_acc++;
      end
      idle();
      n_cyc++;
    end
    InValid = 1'b0;
    Stall = 1'b0;
    idle();
    idle();
    chk("rand_accepted", 32'(n_acc), 32'd1000);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rand_r%0d", i),
          32'(dut.u_rf.regs_q[i]), 32'(ref_regs[i]));
    chk("rand_flags", 32'(Flags), 32'(ref_flags));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
